// File: rtl/video_timing_gen.sv
// Raster timing source: free-running x/y counters with registered display-enable,
// sync and start-of-line/frame flags. Every output describes the same pixel.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       vde,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries are held one bit wider than the counters so that an
  // end-of-region value equal to 1024 still compares correctly.
  localparam logic [10:0] H_LAST_W     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST_W     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [9:0] H_LAST = H_LAST_W[9:0];
  localparam logic [9:0] V_LAST = V_LAST_W[9:0];

  // The 10-bit coordinate outputs can only describe rasters up to 1024x1024.
  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("video_timing_gen: H_TOTAL=%0d does not fit the 10-bit x counter", H_TOTAL);
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("video_timing_gen: V_TOTAL=%0d does not fit the 10-bit y counter", V_TOTAL);
  end
  if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_active
    $error("video_timing_gen: active region must be at least one pixel");
  end

  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       vde_next;
  logic       hsync_next;
  logic       vsync_next;
  logic       line_start_next;
  logic       frame_start_next;
  logic       h_in_sync;
  logic       v_in_sync;

  // Raster position that the next advancing ce will move to.
  always_comb begin
    h_wrap = (x == H_LAST);
    v_wrap = (y == V_LAST);
    x_next = 10'd0;
    y_next = y;
    if (!h_wrap) begin
      x_next = x + 10'd1;
    end
    if (h_wrap) begin
      y_next = v_wrap ? 10'd0 : (y + 10'd1);
    end
  end

  // Flags decoded from the next position so that, once registered, they line
  // up with x/y on the same cycle; vsync follows y and so changes only at x=0.
  always_comb begin
    vde_next         = ({1'b0, x_next} < H_ACT_END) && ({1'b0, y_next} < V_ACT_END);
    h_in_sync        = ({1'b0, x_next} >= H_SYNC_START) && ({1'b0, x_next} < H_SYNC_END);
    v_in_sync        = ({1'b0, y_next} >= V_SYNC_START) && ({1'b0, y_next} < V_SYNC_END);
    hsync_next       = h_in_sync ? HS_POL : ~HS_POL;
    vsync_next       = v_in_sync ? VS_POL : ~VS_POL;
    line_start_next  = (x_next == 10'd0);
    frame_start_next = (x_next == 10'd0) && (y_next == 10'd0);
  end

  // Output registers: reset parks on the last blanking pixel so the first ce
  // lands on (0,0); without ce the raster holds and the pulses drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= H_LAST;
      y           <= V_LAST;
      vde         <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      x           <= x_next;
      y           <= y_next;
      vde         <= vde_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      line_start  <= line_start_next;
      frame_start <= frame_start_next;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a default-timing instance (A) for the
// horizontal behaviour and a small-raster instance (B) for frame-level behaviour.
module tb_video_timing_gen;

  typedef struct {
    int unsigned edge_no;
    bit          dut;
    string       name;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vde;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } expect_t;

  logic       clk;
  logic       rst_a, ce_a, rst_b, ce_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       vde_a, hsync_a, vsync_a, line_start_a, frame_start_a;
  logic       vde_b, hsync_b, vsync_b, line_start_b, frame_start_b;

  expect_t     sb_queue[$];
  expect_t     cur;
  int unsigned edge_count = 0;
  int unsigned base = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  bit          stim_done = 0;
  bit          final_done = 0;

  // Measurements gathered by the monitor from the output waveforms.
  logic a_hs_prev = 1'bx;
  bit   a_hs_counting = 0;
  bit   a_hs_done = 0;
  int   a_hs_len = 0;
  int   a_hs_first = 0;
  int   a_vde_in_hs = 0;
  logic b_vs_prev = 1'bx;
  bit   b_vs_counting = 0;
  bit   b_vs_done = 0;
  int   b_vs_len = 0;
  int   b_vs_first = 0;
  int   b_vde_in_vs = 0;
  int   b_fs_first_edge = -1;
  int   b_fs_period = 0;
  bit   b_fs_done = 0;

  video_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .ce(ce_a),
    .x(x_a), .y(y_a), .vde(vde_a), .hsync(hsync_a), .vsync(vsync_a),
    .line_start(line_start_a), .frame_start(frame_start_a)
  );

  // B raster: 15 x 10, hsync active-high on x=10..12, vsync active-low on y=7..8.
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .ce(ce_b),
    .x(x_b), .y(y_b), .vde(vde_b), .hsync(hsync_b), .vsync(vsync_b),
    .line_start(line_start_b), .frame_start(frame_start_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      edge_count++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // One call = one clock edge: inputs are set at a falling edge and the task
  // returns at the next falling edge, after the DUTs have sampled them.
  task automatic applyStimulus(input logic ra, input logic ca, input logic rb, input logic cb);
    rst_a = ra;
    ce_a  = ca;
    rst_b = rb;
    ce_b  = cb;
    @(negedge clk);
  endtask

  task automatic expectAt(input bit dut, input int offset, input string name,
                          input int ex, input int ey, input logic evde, input logic ehs,
                          input logic evs, input logic els, input logic efs);
    expect_t e;
    e.edge_no = base + offset;
    e.dut  = dut;
    e.name = name;
    e.x    = 10'(ex);
    e.y    = 10'(ey);
    e.vde  = evde;
    e.hs   = ehs;
    e.vs   = evs;
    e.ls   = els;
    e.fs   = efs;
    sb_queue.push_back(e);
  endtask

  function automatic logic [31:0] pack_out(input bit dut);
    if (dut) return {7'd0, x_b, y_b, vde_b, hsync_b, vsync_b, line_start_b, frame_start_b};
    return {7'd0, x_a, y_a, vde_a, hsync_a, vsync_a, line_start_a, frame_start_a};
  endfunction

  // Monitor: pops every expectation due on this edge and compares it; also
  // measures sync widths and frame period straight from the outputs.
  initial begin
    forever begin
      @(negedge clk);
      while (sb_queue.size() > 0 && sb_queue[0].edge_no <= edge_count) begin
        cur = sb_queue.pop_front();
        if (cur.edge_no != edge_count) begin
          checkOutput({cur.name, " (missed edge)"}, edge_count, cur.edge_no);
        end else begin
          checkOutput({cur.name, " {x,y,vde,hs,vs,ls,fs}"}, pack_out(cur.dut),
                      {7'd0, cur.x, cur.y, cur.vde, cur.hs, cur.vs, cur.ls, cur.fs});
        end
      end

      if (a_hs_counting) begin
        if (hsync_a === 1'b0) a_hs_len++;
        else begin
          a_hs_counting = 0;
          if (!a_hs_done) begin
            a_hs_first = a_hs_len;
            a_hs_done  = 1;
          end
        end
      end else if (a_hs_prev === 1'b1 && hsync_a === 1'b0) begin
        a_hs_counting = 1;
        a_hs_len      = 1;
      end
      a_hs_prev = hsync_a;
      if (vde_a === 1'b1 && hsync_a === 1'b0) a_vde_in_hs++;

      if (b_vs_counting) begin
        if (vsync_b === 1'b0) b_vs_len++;
        else begin
          b_vs_counting = 0;
          if (!b_vs_done) begin
            b_vs_first = b_vs_len;
            b_vs_done  = 1;
          end
        end
      end else if (b_vs_prev === 1'b1 && vsync_b === 1'b0) begin
        b_vs_counting = 1;
        b_vs_len      = 1;
      end
      b_vs_prev = vsync_b;
      if (vde_b === 1'b1 && vsync_b === 1'b0) b_vde_in_vs++;

      if (frame_start_b === 1'b1 && !b_fs_done) begin
        if (b_fs_first_edge < 0) b_fs_first_edge = int'(edge_count);
        else begin
          b_fs_period = int'(edge_count) - b_fs_first_edge;
          b_fs_done   = 1;
        end
      end

      if (stim_done && !final_done) begin
        checkOutput("A hsync low width", a_hs_first, 96);
        checkOutput("A vde during hsync", a_vde_in_hs, 0);
        checkOutput("B vsync low width", b_vs_first, 30);
        checkOutput("B vde during vsync", b_vde_in_vs, 0);
        checkOutput("B frame_start period", b_fs_period, 150);
        checkOutput("scoreboard drained", sb_queue.size(), 0);
        final_done = 1;
      end
    end
  end

  initial begin
    rst_a = 1'b1; ce_a = 1'b0; rst_b = 1'b1; ce_b = 1'b0;
    @(negedge clk);

    // A: reset for three clocks, ce high on the last one must not matter.
    base = edge_count;
    expectAt(0, 1, "A reset",         799, 524, 0, 1, 1, 0, 0);
    expectAt(0, 3, "A reset with ce", 799, 524, 0, 1, 1, 0, 0);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 1, 1, 0);

    // A: continuous ce through the first line and into the second.
    base = edge_count;
    expectAt(0,    1, "A first ce (0,0)",  0,   0, 1, 1, 1, 1, 1);
    expectAt(0,    2, "A (1,0)",           1,   0, 1, 1, 1, 0, 0);
    expectAt(0,  640, "A last active x",   639, 0, 1, 1, 1, 0, 0);
    expectAt(0,  641, "A x=640 blank",     640, 0, 0, 1, 1, 0, 0);
    expectAt(0,  656, "A x=655 pre-sync",  655, 0, 0, 1, 1, 0, 0);
    expectAt(0,  657, "A hsync falls",     656, 0, 0, 0, 1, 0, 0);
    expectAt(0,  752, "A hsync last low",  751, 0, 0, 0, 1, 0, 0);
    expectAt(0,  753, "A hsync rises",     752, 0, 0, 1, 1, 0, 0);
    expectAt(0,  800, "A end of line 0",   799, 0, 0, 1, 1, 0, 0);
    expectAt(0,  801, "A line wrap (0,1)", 0,   1, 1, 1, 1, 1, 0);
    expectAt(0, 1101, "A (300,1)",         300, 1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 1101; i++) applyStimulus(0, 1, 1, 0);

    // A: reset mid-line in the active region, then restart and run into hsync.
    base = edge_count;
    expectAt(0,   1, "A reset mid-frame", 799, 524, 0, 1, 1, 0, 0);
    expectAt(0,   2, "A restart (0,0)",   0,   0,   1, 1, 1, 1, 1);
    expectAt(0, 702, "A (700,0) in sync", 700, 0,   0, 0, 1, 0, 0);
    applyStimulus(1, 1, 1, 0);
    for (int i = 0; i < 701; i++) applyStimulus(0, 1, 1, 0);

    // A: reset while hsync is active, hold with ce low, then restart.
    base = edge_count;
    expectAt(0, 1, "A reset in hsync",  799, 524, 0, 1, 1, 0, 0);
    expectAt(0, 2, "A hold after rst",  799, 524, 0, 1, 1, 0, 0);
    expectAt(0, 3, "A restart again",   0,   0,   1, 1, 1, 1, 1);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);

    // B: full frame with continuous ce.
    base = edge_count;
    expectAt(1, 1, "B reset", 14, 9, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0);
    base = edge_count;
    expectAt(1,   1, "B first ce (0,0)",   0,  0, 1, 0, 1, 1, 1);
    expectAt(1,  11, "B hsync on x=10",    10, 0, 0, 1, 1, 0, 0);
    expectAt(1,  13, "B hsync on x=12",    12, 0, 0, 1, 1, 0, 0);
    expectAt(1,  14, "B hsync off x=13",   13, 0, 0, 0, 1, 0, 0);
    expectAt(1,  15, "B end of line 0",    14, 0, 0, 0, 1, 0, 0);
    expectAt(1,  16, "B line wrap (0,1)",  0,  1, 1, 0, 1, 1, 0);
    expectAt(1,  91, "B (0,6) vblank",     0,  6, 0, 0, 1, 1, 0);
    expectAt(1, 105, "B (14,6) pre-vsync", 14, 6, 0, 0, 1, 0, 0);
    expectAt(1, 106, "B vsync on (0,7)",   0,  7, 0, 0, 0, 1, 0);
    expectAt(1, 135, "B vsync (14,8)",     14, 8, 0, 0, 0, 0, 0);
    expectAt(1, 136, "B vsync off (0,9)",  0,  9, 0, 0, 1, 1, 0);
    expectAt(1, 150, "B last pixel",       14, 9, 0, 0, 1, 0, 0);
    expectAt(1, 151, "B frame wrap (0,0)", 0,  0, 1, 0, 1, 1, 1);
    expectAt(1, 152, "B (1,0) 2nd frame",  1,  0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 160; i++) applyStimulus(1, 0, 0, 1);

    // B: ce on one clock in four.
    base = edge_count;
    expectAt(1, 1, "B reset again", 14, 9, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0);
    base = edge_count;
    expectAt(1,   1, "B gated first ce",   0,  0, 1, 0, 1, 1, 1);
    expectAt(1,   2, "B gated hold 1",     0,  0, 1, 0, 1, 0, 0);
    expectAt(1,   4, "B gated hold 3",     0,  0, 1, 0, 1, 0, 0);
    expectAt(1,   5, "B gated (1,0)",      1,  0, 1, 0, 1, 0, 0);
    expectAt(1,  41, "B gated hsync",      10, 0, 0, 1, 1, 0, 0);
    expectAt(1,  44, "B gated hsync hold", 10, 0, 0, 1, 1, 0, 0);
    expectAt(1,  61, "B gated line start", 0,  1, 1, 0, 1, 1, 0);
    expectAt(1,  62, "B gated ls width",   0,  1, 1, 0, 1, 0, 0);
    expectAt(1, 601, "B gated frame wrap", 0,  0, 1, 0, 1, 1, 1);
    expectAt(1, 602, "B gated fs width",   0,  0, 1, 0, 1, 0, 0);
    expectAt(1, 605, "B gated (1,0)",      1,  0, 1, 0, 1, 0, 0);
    for (int m = 0; m < 152; m++) begin
      applyStimulus(1, 0, 0, 1);
      for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0);
    end

    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 0, 1, 0);
    stim_done = 1;
    repeat (3) @(negedge clk);
    if (!final_done) begin
      $display("[TB] FAIL final checks: not reached");
      tests_failed++;
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
